// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs an incoming byte stream little-endian into 32-bit words.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        full
);

    logic [BYTE_IDX_W-1:0] cnt_q, cnt_d;
    logic [31:0]           word_q, word_d;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr) begin
            cnt_d = '0;
        end else if (byte_en) begin
            word_d[{cnt_q, 3'b000} +: 8] = byte_in;
            cnt_d                        = cnt_q + 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    // NOTE: the lane register is reset too, because it drives wdata, which must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_out = word_q;
    assign full     = byte_en && (cnt_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory and holds the core in reset meanwhile.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] len_words,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [WIDTH-1:0]      wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int LEN_W = ADDR_WIDTH - 1;
    localparam int DEPTH = 2 ** IDX_W;

    loader_state_t     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              err_q, err_d;

    logic              can_start;
    logic              byte_en;
    logic              word_full;
    logic [31:0]       word;
    logic [LEN_W-1:0]  idx_inc;

    assign can_start = start && (state_q == IDLE || state_q == DONE);
    assign byte_en   = s_valid && s_ready;
    // One bit wider than the index so that a full-depth load compares equal to len_words.
    assign idx_inc   = LEN_W'(idx_q) + 1'b1;

    word_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (can_start),
        .byte_en  (byte_en),
        .byte_in  (s_data),
        .word_out (word),
        .full     (word_full)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (can_start) begin
                    len_d = len_words;
                    idx_d = '0;
                    err_d = 1'b0;
                    if (len_words > LEN_W'(DEPTH)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (len_words == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (word_full) state_d = WRITE;
            end
            WRITE: begin
                idx_d   = idx_inc[IDX_W-1:0];
                state_d = (idx_inc == len_q) ? DONE : FILL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign s_ready = (state_q == FILL);
    assign we      = (state_q == WRITE);
    assign waddr   = {idx_q, 2'b00};
    assign wdata   = WIDTH'(word);
    assign busy    = (state_q == FILL) || (state_q == WRITE);
    assign done    = (state_q == DONE);
    assign err     = err_q;
    assign cpu_rst = rst || busy;

endmodule
